// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two requesters (A = execute, B = load) and the
// register-file write port arbiter, including the forwarding and stats outputs.
interface rf_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  // Handshake: a requester raises *_valid with *_wsel/*_wdat and holds them
  // stable until *_ready is seen high in the same cycle; a transfer happens
  // on any rising edge where valid && ready. Valid may drop without ready
  // (the request is withdrawn). The arbiter never buffers a denied request.
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_wsel;
  logic [DW-1:0] a_wdat;

  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_wsel;
  logic [DW-1:0] b_wdat;

  logic          rf_WEN;
  logic [AW-1:0] rf_wsel;
  logic [DW-1:0] rf_wdat;

  logic          fwd_valid;
  logic [AW-1:0] fwd_wsel;
  logic [DW-1:0] fwd_wdat;

  logic [15:0]   conflict_cnt;

  modport slave (
    input  a_valid, a_wsel, a_wdat,
    input  b_valid, b_wsel, b_wdat,
    output a_ready, b_ready,
    output rf_WEN, rf_wsel, rf_wdat,
    output fwd_valid, fwd_wsel, fwd_wdat,
    output conflict_cnt
  );

  modport master (
    output a_valid, a_wsel, a_wdat,
    output b_valid, b_wsel, b_wdat,
    input  a_ready, b_ready,
    input  rf_WEN, rf_wsel, rf_wdat,
    input  fwd_valid, fwd_wsel, fwd_wdat,
    input  conflict_cnt
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: B-priority with a starvation guard for A,
// registered write stage doubling as a forwarding source. Macro RF_WB_STATS_EN enables conflict_cnt.
module rf_wb_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic            CLK,
  input  logic            nRST,
  rf_wb_arbiter_if.slave  bus,
  output logic [3:0]      dbg_wait
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]    wait_cnt;
  logic          force_a;
  logic          grant_a;
  logic          grant_b;
  logic [AW-1:0] sel_wsel;
  logic [DW-1:0] sel_wdat;

  logic          wen_q;
  logic [AW-1:0] wsel_q;
  logic [DW-1:0] wdat_q;

  // A is only forced past B when they target different registers, so that
  // same-register writes always retire in B-then-A order.
  always_comb begin
    force_a  = (wait_cnt == MAX_W) && (bus.a_wsel != bus.b_wsel);
    grant_a  = nRST && bus.a_valid && (!bus.b_valid || force_a);
    grant_b  = nRST && bus.b_valid && !(bus.a_valid && force_a);
    sel_wsel = grant_a ? bus.a_wsel : bus.b_wsel;
    sel_wdat = grant_a ? bus.a_wdat : bus.b_wdat;
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wait_cnt <= 4'd0;
    end else if (bus.a_valid && !grant_a) begin
      if (wait_cnt != MAX_W) wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  // Writes to r0 still consume the slot but never raise the enable.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wen_q  <= 1'b0;
      wsel_q <= '0;
      wdat_q <= '0;
    end else if (grant_a || grant_b) begin
      wen_q  <= (sel_wsel != '0);
      wsel_q <= sel_wsel;
      wdat_q <= sel_wdat;
    end else begin
      wen_q  <= 1'b0;
    end
  end

  assign bus.rf_WEN    = wen_q;
  assign bus.rf_wsel   = wsel_q;
  assign bus.rf_wdat   = wdat_q;
  assign bus.fwd_valid = wen_q;
  assign bus.fwd_wsel  = wsel_q;
  assign bus.fwd_wdat  = wdat_q;
  assign dbg_wait      = wait_cnt;

`ifdef RF_WB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      conflict_q <= 16'h0000;
    end else if (bus.a_valid && bus.b_valid && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'h0001;
    end
  end

  assign bus.conflict_cnt = conflict_q;
`else
  assign bus.conflict_cnt = 16'h0000;
`endif

endmodule
